// File: rtl/partition_sweep_ctrl.sv
// partition_sweep_ctrl
//   Exhaustive truth-table sweep of an approximate combinational partition
//   against its exact counterpart. Every input vector 0..2^N_IN-1 is driven
//   on pi in ascending order. After a settle window both partition outputs are
//   sampled, the approximate word is offered as a valid/ready record, and the
//   error metrics are accumulated once per accepted vector.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   start, abort      begin a sweep (IDLE only); cancel a sweep (highest priority)
//   pi                input vector driven to both partitions
//   po_approx/exact   partition outputs
//   rec_valid/ready   record handshake; rec_idx / rec_data carry the vector and sample
//   busy, done        sweep in progress; one-cycle completion pulse
//   aborted           one-cycle cancellation pulse
//   mismatch_cnt      vectors whose outputs differ
//   hamming_sum       total differing output bits
//   max_abs_err       largest |approx - exact|
module partition_sweep_ctrl #(
  parameter int unsigned N_IN       = 7,
  parameter int unsigned N_OUT      = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  output logic [N_IN-1:0]                     pi,
  input  logic [N_OUT-1:0]                    po_approx,
  input  logic [N_OUT-1:0]                    po_exact,
  output logic                                rec_valid,
  input  logic                                rec_ready,
  output logic [N_IN-1:0]                     rec_idx,
  output logic [N_OUT-1:0]                    rec_data,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted,
  output logic [N_IN:0]                       mismatch_cnt,
  output logic [N_IN+$clog2(N_OUT+1)-1:0]     hamming_sum,
  output logic [N_OUT-1:0]                    max_abs_err
);

  localparam int unsigned HdW = $clog2(N_OUT + 1);
  localparam int unsigned HsW = N_IN + HdW;
  localparam int unsigned MmW = N_IN + 1;
  // With no settle window the partition is observed live in the single cycle
  // pi is held; pi stays constant for the whole SAMPLE stay, so the record
  // remains stable under back-pressure.
  localparam bit LiveSample = (SETTLE_CYC == 0);
  localparam logic [3:0] CntLoad = LiveSample ? 4'd0 : 4'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] PiOne = N_IN'(1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_IN-1:0]   pi_q, pi_d;
  logic [N_IN-1:0]   rec_idx_q, rec_idx_d;
  logic [N_OUT-1:0]  cap_a_q, cap_a_d;
  logic [N_OUT-1:0]  cap_e_q, cap_e_d;
  logic              rec_valid_q, rec_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [MmW-1:0]    mm_q, mm_d;
  logic [HsW-1:0]    hs_q, hs_d;
  logic [N_OUT-1:0]  mx_q, mx_d;

  logic [N_OUT-1:0]  smp_a, smp_e, diff_bits, abs_err;
  logic [HdW-1:0]    hd;
  logic              last_vec;

  // Per-vector error terms from the sampled pair.
  always_comb begin
    smp_a     = LiveSample ? po_approx : cap_a_q;
    smp_e     = LiveSample ? po_exact  : cap_e_q;
    diff_bits = smp_a ^ smp_e;
    hd        = '0;
    for (int i = 0; i < N_OUT; i++) begin
      hd = hd + HdW'(diff_bits[i]);
    end
    // The magnitude of a difference of two N_OUT-bit values always fits in N_OUT bits.
    abs_err   = (smp_a >= smp_e) ? (smp_a - smp_e) : (smp_e - smp_a);
    last_vec  = &pi_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pi_d        = pi_q;
    rec_idx_d   = rec_idx_q;
    cap_a_d     = cap_a_q;
    cap_e_d     = cap_e_q;
    rec_valid_d = rec_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    mm_d        = mm_q;
    hs_d        = hs_q;
    mx_d        = mx_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          mm_d   = '0;
          hs_d   = '0;
          mx_d   = '0;
          pi_d   = '0;
          busy_d = 1'b1;
          if (LiveSample) begin
            state_d     = StSample;
            rec_valid_d = 1'b1;
            rec_idx_d   = '0;
          end else begin
            state_d = StSettle;
            cnt_d   = CntLoad;
          end
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d     = StSample;
          rec_valid_d = 1'b1;
          rec_idx_d   = pi_q;
          cap_a_d     = po_approx;
          cap_e_d     = po_exact;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        if (rec_ready) begin
          mm_d        = mm_q + MmW'(smp_a != smp_e);
          hs_d        = hs_q + HsW'(hd);
          mx_d        = (abs_err > mx_q) ? abs_err : mx_q;
          rec_valid_d = 1'b0;
          if (last_vec) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pi_d = pi_q + PiOne;
            if (LiveSample) begin
              rec_valid_d = 1'b1;
              rec_idx_d   = pi_q + PiOne;
            end else begin
              state_d = StSettle;
              cnt_d   = CntLoad;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything, including a same-cycle accept.
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      rec_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      aborted_d   = 1'b1;
      mm_d        = mm_q;
      hs_d        = hs_q;
      mx_d        = mx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pi_q        <= '0;
      rec_idx_q   <= '0;
      cap_a_q     <= '0;
      cap_e_q     <= '0;
      rec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      mm_q        <= '0;
      hs_q        <= '0;
      mx_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pi_q        <= pi_d;
      rec_idx_q   <= rec_idx_d;
      cap_a_q     <= cap_a_d;
      cap_e_q     <= cap_e_d;
      rec_valid_q <= rec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      mm_q        <= mm_d;
      hs_q        <= hs_d;
      mx_q        <= mx_d;
    end
  end

  assign pi           = pi_q;
  assign rec_valid    = rec_valid_q;
  assign rec_idx      = rec_idx_q;
  assign rec_data     = rec_valid_q ? smp_a : '0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign mismatch_cnt = mm_q;
  assign hamming_sum  = hs_q;
  assign max_abs_err  = mx_q;

endmodule
